// File: rtl/eth_tx_pkt_gen.sv
// Test packet generator feeding eth_tx's byte-stream interface in the Eth_Clk domain.
// Emits patterned payloads as single shots or a gapped continuous stream, pacing on Tx_Busy.
module eth_tx_pkt_gen #(
    parameter int PAYLOAD_LEN = 100,
    parameter int GAP_CYCLES  = 1000,
    parameter int TX_TIMEOUT  = 4096
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Test_En,
    input  logic        Continuous,
    input  logic [1:0]  Pattern_Sel,
    input  logic        Tx_Busy,
    output logic [7:0]  Eth_Byte,
    output logic        Eth_Byte_Valid,
    output logic        Eth_Pkt_Rdy,
    output logic        Gen_Busy,
    output logic [15:0] Pkt_Count,
    output logic        Tx_Timeout_Err
);

    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam int TMO_W = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, SEND, DONE, WAIT_TX, GAP} state_t;

    state_t           state;
    logic             en_meta, en_s, en_r;
    logic             start;
    logic [1:0]       pat_r;
    logic [10:0]      byte_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             seen_busy;
    logic [7:0]       lfsr;
    logic             tmo_hit, wait_exit, gap_exit;

    // Fibonacci x^8+x^6+x^5+x^4+1, shifting towards the MSB
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] pattern_byte(input logic [1:0] sel, input logic [10:0] n,
                                                input logic [7:0] lfsr_val);
        case (sel)
            2'b00:   return n[7:0];
            2'b01:   return 8'hA5;
            2'b10:   return lfsr_val;
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            en_meta <= 1'b0;
            en_s    <= 1'b0;
            en_r    <= 1'b0;
        end else begin
            en_meta <= Test_En;
            en_s    <= en_meta;
            en_r    <= en_s;
        end
    end

    assign start     = en_s & ~en_r;
    assign tmo_hit   = (state == WAIT_TX) && !seen_busy && !Tx_Busy &&
                       (tmo_cnt == TMO_W'(TX_TIMEOUT - 1));
    assign wait_exit = tmo_hit || ((state == WAIT_TX) && seen_busy && !Tx_Busy);
    // A zero-length gap makes the repeat/idle decision on the WAIT_TX exit cycle itself
    assign gap_exit  = ((state == GAP) && (gap_cnt == GAP_W'(GAP_CYCLES - 1))) ||
                       (wait_exit && (GAP_CYCLES == 0));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state          <= IDLE;
            pat_r          <= 2'b00;
            byte_cnt       <= '0;
            gap_cnt        <= '0;
            tmo_cnt        <= '0;
            seen_busy      <= 1'b0;
            lfsr           <= 8'hFF;
            Eth_Byte       <= 8'h00;
            Eth_Byte_Valid <= 1'b0;
            Eth_Pkt_Rdy    <= 1'b0;
            Gen_Busy       <= 1'b0;
            Pkt_Count      <= 16'h0000;
            Tx_Timeout_Err <= 1'b0;
        end else begin
            Eth_Byte       <= 8'h00;
            Eth_Byte_Valid <= 1'b0;
            Eth_Pkt_Rdy    <= 1'b0;

            case (state)
                IDLE: begin
                    if (start || (en_s && Continuous)) begin
                        state    <= SEND;
                        pat_r    <= Pattern_Sel;
                        byte_cnt <= '0;
                        Gen_Busy <= 1'b1;
                    end
                end
                SEND: begin
                    Eth_Byte_Valid <= 1'b1;
                    Eth_Byte       <= pattern_byte(pat_r, byte_cnt + 11'd1, lfsr);
                    if (pat_r == 2'b10)
                        lfsr <= lfsr_next(lfsr);
                    byte_cnt <= byte_cnt + 11'd1;
                    if (byte_cnt == 11'(PAYLOAD_LEN - 1))
                        state <= DONE;
                end
                DONE: begin
                    Eth_Pkt_Rdy <= 1'b1;
                    Pkt_Count   <= Pkt_Count + 16'd1;
                    tmo_cnt     <= '0;
                    seen_busy   <= 1'b0;
                    state       <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (Tx_Busy)
                        seen_busy <= 1'b1;
                    else if (!seen_busy)
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (tmo_hit)
                        Tx_Timeout_Err <= 1'b1;
                    if (wait_exit) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: state <= IDLE;
            endcase

            // Continuous and en_s are only consulted here, so mid-stream changes wait for the gap end
            if (gap_exit) begin
                if (Continuous && en_s) begin
                    state    <= SEND;
                    pat_r    <= Pattern_Sel;
                    byte_cnt <= '0;
                end else begin
                    state    <= IDLE;
                    Gen_Busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_pkt_gen.sv
// Bench for eth_tx_pkt_gen: packet-level reference model plus directed scenarios.
module tb_eth_tx_pkt_gen;

    localparam int LEN = 100;
    localparam int GAP = 10;
    localparam int TMO = 16;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Test_En;
    logic        Continuous;
    logic [1:0]  Pattern_Sel;
    logic        Tx_Busy;
    logic [7:0]  Eth_Byte;
    logic        Eth_Byte_Valid;
    logic        Eth_Pkt_Rdy;
    logic        Gen_Busy;
    logic [15:0] Pkt_Count;
    logic        Tx_Timeout_Err;

    eth_tx_pkt_gen #(.PAYLOAD_LEN(LEN), .GAP_CYCLES(GAP), .TX_TIMEOUT(TMO)) dut (
        .Clk(Clk), .Rst(Rst), .Test_En(Test_En), .Continuous(Continuous),
        .Pattern_Sel(Pattern_Sel), .Tx_Busy(Tx_Busy), .Eth_Byte(Eth_Byte),
        .Eth_Byte_Valid(Eth_Byte_Valid), .Eth_Pkt_Rdy(Eth_Pkt_Rdy), .Gen_Busy(Gen_Busy),
        .Pkt_Count(Pkt_Count), .Tx_Timeout_Err(Tx_Timeout_Err)
    );

    always #10 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Reference model state
    int       pat_q[$];
    int       cur_pat = 0;
    bit       in_pkt = 0;
    int       idx = 0;
    int       lfsr_m = 'hFF;
    int       pkt_exp = 0;
    int       pkt_bytes[LEN];
    int       pkts_seen = 0;
    int       pkts_started = 0;
    int       first_byte_cyc = 0;
    int       rdy_cyc = 0;
    int       busy_fall_cyc = 0;
    bit       busy_en = 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Bit shifted in is the parity of the polynomial taps x^8, x^6, x^5, x^4
    function automatic int lfsr_step(input int s);
        int fb;
        fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
        return ((s << 1) | fb) & 'hFF;
    endfunction

    initial begin : compare
        int exp_b;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                in_pkt  = 0;
                idx     = 0;
                pkt_exp = 0;
                lfsr_m  = 'hFF;
                pat_q.delete();
            end else if (Eth_Byte_Valid) begin
                check("busy_while_sending", int'(Gen_Busy), 1);
                check("rdy_during_send", int'(Eth_Pkt_Rdy), 0);
                if (!in_pkt) begin
                    in_pkt = 1;
                    idx = 0;
                    pkts_started++;
                    first_byte_cyc = cyc;
                    if (pat_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_packet: got a packet start want none at cycle %0d", cyc);
                        cur_pat = 0;
                    end else begin
                        cur_pat = pat_q.pop_front();
                    end
                end
                idx++;
                case (cur_pat)
                    0: exp_b = idx % 256;
                    1: exp_b = 'hA5;
                    2: begin exp_b = lfsr_m; lfsr_m = lfsr_step(lfsr_m); end
                    default: exp_b = 0;
                endcase
                if (idx <= LEN) pkt_bytes[idx-1] = int'(Eth_Byte);
                check("payload_byte", int'(Eth_Byte), exp_b);
            end else begin
                check("idle_byte_zero", int'(Eth_Byte), 0);
                if (in_pkt) begin
                    in_pkt = 0;
                    check("pkt_len", idx, LEN);
                    check("pkt_rdy_after_last", int'(Eth_Pkt_Rdy), 1);
                    check("busy_at_rdy", int'(Gen_Busy), 1);
                    pkt_exp = (pkt_exp + 1) % 65536;
                    check("pkt_count", int'(Pkt_Count), pkt_exp);
                    pkts_seen++;
                    rdy_cyc = cyc;
                end else begin
                    check("no_spurious_rdy", int'(Eth_Pkt_Rdy), 0);
                end
            end
        end
    end

    // eth_tx stand-in: busy for 50 cycles starting 3 cycles after each Pkt_Rdy
    initial begin : busy_model
        Tx_Busy = 1'b0;
        forever begin
            @(negedge Clk);
            if (busy_en && Eth_Pkt_Rdy && !Rst) begin
                repeat (3) @(posedge Clk);
                #1 Tx_Busy = 1'b1;
                repeat (50) @(posedge Clk);
                #1 Tx_Busy = 1'b0;
                busy_fall_cyc = cyc;
            end
        end
    end

    initial begin : watchdog
        #(20 * 30000);
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_pkts(input int target, input int budget);
        int n = 0;
        while (pkts_seen < target && n < budget) begin @(negedge Clk); #1; n++; end
        check("pkt_completed_in_time", int'(pkts_seen >= target), 1);
    endtask

    task automatic wait_started(input int target, input int budget);
        int n = 0;
        while (pkts_started < target && n < budget) begin @(negedge Clk); #1; n++; end
        check("pkt_started_in_time", int'(pkts_started >= target), 1);
    endtask

    task automatic wait_idx(input int k, input int budget);
        int n = 0;
        while (!(in_pkt && idx >= k) && n < budget) begin @(negedge Clk); #1; n++; end
        check("reached_byte", int'(in_pkt && idx >= k), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (Gen_Busy && n < budget) begin @(negedge Clk); #1; n++; end
        check("returned_idle", int'(Gen_Busy), 0);
    endtask

    task automatic pulse_en();
        Test_En = 1'b1;
        tick(8);
        Test_En = 1'b0;
    endtask

    initial begin : stim
        int en_cyc, base, err_cyc, n;
        Rst = 1'b1; Test_En = 1'b0; Continuous = 1'b0; Pattern_Sel = 2'b00;
        tick(3);
        check("rst_byte", int'(Eth_Byte), 0);
        check("rst_valid", int'(Eth_Byte_Valid), 0);
        check("rst_rdy", int'(Eth_Pkt_Rdy), 0);
        check("rst_busy", int'(Gen_Busy), 0);
        check("rst_count", int'(Pkt_Count), 0);
        check("rst_err", int'(Tx_Timeout_Err), 0);
        Rst = 1'b0;
        tick(3);

        // Single shot, incrementing: 2 sync + 1 FSM + 1 output register = 4 cycles
        pat_q.push_back(0);
        en_cyc = cyc;
        pulse_en();
        wait_pkts(1, 300);
        check("start_latency", first_byte_cyc - en_cyc, 4);
        check("incr_first", pkt_bytes[0], 'h01);
        check("incr_last", pkt_bytes[LEN-1], 'h64);
        check("single_count", int'(Pkt_Count), 1);
        wait_idle(300);
        tick(30);
        check("no_second_pkt", pkts_started, 1);

        // LFSR from its reset seed
        Pattern_Sel = 2'b10;
        pat_q.push_back(2);
        pulse_en();
        wait_pkts(2, 300);
        check("lfsr_b0", pkt_bytes[0], 'hFF);
        check("lfsr_b1", pkt_bytes[1], 'hFE);
        check("lfsr_b2", pkt_bytes[2], 'hFC);
        check("lfsr_b3", pkt_bytes[3], 'hF8);
        wait_idle(300);

        // Constant 0xA5 with Pattern_Sel changed mid-packet, then the new pattern
        Pattern_Sel = 2'b01;
        pat_q.push_back(1);
        Test_En = 1'b1;
        wait_idx(10, 60);
        Pattern_Sel = 2'b11;
        Test_En = 1'b0;
        wait_pkts(3, 300);
        check("a5_held_last", pkt_bytes[LEN-1], 'hA5);
        wait_idle(300);
        pat_q.push_back(3);
        pulse_en();
        wait_pkts(4, 300);
        check("zero_pattern_first", pkt_bytes[0], 0);
        wait_idle(300);

        // Test_En dropped at byte 40: packet still completes
        Pattern_Sel = 2'b00;
        pat_q.push_back(0);
        Test_En = 1'b1;
        wait_idx(40, 60);
        Test_En = 1'b0;
        wait_pkts(5, 300);
        check("disable_last", pkt_bytes[LEN-1], 'h64);
        wait_idle(300);
        tick(30);
        check("disable_no_restart", pkts_started, 5);

        // Continuous: 1 cycle to see Tx_Busy low + GAP cycles + 1 output register
        Continuous = 1'b1;
        repeat (3) pat_q.push_back(0);
        base = int'(Pkt_Count);
        Test_En = 1'b1;
        wait_started(7, 600);
        check("gap_pkt2", first_byte_cyc - busy_fall_cyc, GAP + 2);
        wait_started(8, 600);
        check("gap_pkt3", first_byte_cyc - busy_fall_cyc, GAP + 2);
        Test_En = 1'b0;
        wait_pkts(8, 300);
        check("cont_count", int'(Pkt_Count) - base, 3);
        wait_idle(300);
        Continuous = 1'b0;
        tick(30);
        check("cont_stopped", pkts_started, 8);

        // Timeout: Tx_Busy never asserts
        busy_en = 0;
        pat_q.push_back(0);
        pulse_en();
        wait_pkts(9, 300);
        check("err_low_before", int'(Tx_Timeout_Err), 0);
        n = 0;
        while (!Tx_Timeout_Err && n < 100) begin @(negedge Clk); #1; n++; end
        err_cyc = cyc;
        check("err_raised", int'(Tx_Timeout_Err), 1);
        check("timeout_delay", err_cyc - rdy_cyc, TMO);
        wait_idle(100);
        check("err_sticky", int'(Tx_Timeout_Err), 1);
        busy_en = 1;

        // Asynchronous reset at byte 20
        pat_q.push_back(0);
        Test_En = 1'b1;
        wait_idx(20, 60);
        #3 Rst = 1'b1;
        #1;
        check("mid_rst_byte", int'(Eth_Byte), 0);
        check("mid_rst_valid", int'(Eth_Byte_Valid), 0);
        check("mid_rst_rdy", int'(Eth_Pkt_Rdy), 0);
        check("mid_rst_busy", int'(Gen_Busy), 0);
        check("mid_rst_count", int'(Pkt_Count), 0);
        check("mid_rst_err", int'(Tx_Timeout_Err), 0);
        Test_En = 1'b0;
        tick(2);
        Rst = 1'b0;
        tick(3);
        pat_q.push_back(0);
        pulse_en();
        wait_pkts(10, 300);
        check("fresh_first", pkt_bytes[0], 'h01);
        check("fresh_count", int'(Pkt_Count), 1);
        wait_idle(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
